// File: rtl/yarvis_spi_mem.sv
// yarvis_spi_mem: byte-wide mode-0 SPI master for external SRAM/flash.
// Optional YARVIS_SPI_FAST_READ_EN: reads use 0x0B plus 8 dummy clocks.
`timescale 1ns/1ps
module yarvis_spi_mem #(
  parameter int ADDR_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [47:0]     tx;
  logic [7:0]      rx;
  logic [7:0]      rx_nxt;
  logic [5:0]      bit_cnt;
  logic [5:0]      last_idx;
  logic [DW-1:0]   div_cnt;
  logic            ph;
  logic [GW-1:0]   gap_cnt;
  logic            we_q;
  logic [7:0]      rdata_q;
  logic [7:0]      cmd;
  logic [47:0]     load;
  logic            accept;
  logic            div_end;
  logic            rise;
  logic            per_end;
  logic            last_bit;
  logic            done;

`ifdef YARVIS_SPI_FAST_READ_EN
  assign cmd      = req_we ? 8'h02 : 8'h0B;
  assign last_idx = we_q ? 6'd39 : 6'd47;
`else
  assign cmd      = req_we ? 8'h02 : 8'h03;
  assign last_idx = 6'd39;
`endif

  // Frame is left-aligned; a fast read's dummy byte is the zero after the address.
  assign load = {cmd, 24'(req_addr),
                 (req_we ? req_wdata : 8'h00), 8'h00};

  assign accept   = (state == IDLE) && req_valid;
  assign div_end  = (div_cnt == DIV_LAST);
  assign rise     = (state == SHIFT) && ph && (div_cnt == '0);
  assign per_end  = (state == SHIFT) && ph && div_end;
  assign last_bit = (bit_cnt == last_idx);
  assign done     = per_end && last_bit;
  assign rx_nxt   = rise ? {rx[6:0], spi_miso} : rx;

  // State register; async reset drops CS at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pin decode.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    spi_cs_n  = 1'b1;
    spi_sck   = 1'b0;
    spi_mosi  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        spi_cs_n = 1'b0;
        spi_sck  = ph;
        spi_mosi = tx[47];
        if (done) state_nxt = GAP;
      end
      GAP: begin
        rsp_valid = (gap_cnt == '0);
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift engine: divider, phase, bit count and the two shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ph      <= 1'b0;
      we_q    <= 1'b0;
    end else if (accept) begin
      tx      <= load;
      rx      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ph      <= 1'b0;
      we_q    <= req_we;
    end else if (state == SHIFT) begin
      rx <= rx_nxt;
      if (div_end) begin
        div_cnt <= '0;
        if (ph) begin
          ph <= 1'b0;
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 6'd1;
            tx      <= {tx[46:0], 1'b0};
          end
        end else begin
          ph <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // CS gap counter and the held response byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (done) begin
        gap_cnt <= '0;
        rdata_q <= we_q ? 8'h00 : rx_nxt;
      end else if ((state == GAP) && (gap_cnt != GAP_LAST)) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  assign rsp_rdata = rdata_q;

endmodule
